// File: rtl/idiv_int_div_iterative.sv
// Iterative restoring divider: one quotient bit per cycle, val/rdy streams in and out.
// Optional macro IDIV_SIGNED_EN enables two's complement operands (default build is unsigned).
module idiv_int_div_iterative #(
    parameter int NBITS = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               istream_val,
    output logic               istream_rdy,
    input  logic [2*NBITS-1:0] istream_msg,
    output logic               ostream_val,
    input  logic               ostream_rdy,
    output logic [2*NBITS-1:0] ostream_msg
);

    localparam int CNT_W = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBITS - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [NBITS-1:0] neg_f(input logic [NBITS-1:0] x);
        return ~x + {{(NBITS-1){1'b0}}, 1'b1};
    endfunction

    state_e               state_q, state_d;
    logic [NBITS:0]       a_q, a_d;
    logic [NBITS-1:0]     q_q, q_d;
    logic [NBITS-1:0]     dvs_q, dvs_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*NBITS-1:0]   res_q, res_d;

    logic [NBITS-1:0]     dvd_in_s, dvs_in_s;
    logic [NBITS-1:0]     dvd_mag_s, dvs_mag_s;
    logic [NBITS+1:0]     shift_s, diff_s;
    logic [NBITS:0]       a_step_s;
    logic [NBITS-1:0]     q_step_s;
    logic [NBITS-1:0]     quo_fix_s, rem_fix_s;

    assign dvd_in_s = istream_msg[2*NBITS-1:NBITS];
    assign dvs_in_s = istream_msg[NBITS-1:0];

`ifdef IDIV_SIGNED_EN
    logic neg_quo_q, neg_quo_d;
    logic neg_rem_q, neg_rem_d;

    assign dvd_mag_s = dvd_in_s[NBITS-1] ? neg_f(dvd_in_s) : dvd_in_s;
    assign dvs_mag_s = dvs_in_s[NBITS-1] ? neg_f(dvs_in_s) : dvs_in_s;
    // Zero divisor keeps quotient all ones (-1) regardless of dividend sign.
    assign quo_fix_s = neg_quo_q ? neg_f(q_step_s) : q_step_s;
    assign rem_fix_s = neg_rem_q ? neg_f(a_step_s[NBITS-1:0]) : a_step_s[NBITS-1:0];
`else
    assign dvd_mag_s = dvd_in_s;
    assign dvs_mag_s = dvs_in_s;
    assign quo_fix_s = q_step_s;
    assign rem_fix_s = a_step_s[NBITS-1:0];
`endif

    // One restoring step: shift {A,Q} left, trial-subtract divisor, keep or restore.
    assign shift_s  = {a_q, q_q[NBITS-1]};
    assign diff_s   = shift_s - {2'b00, dvs_q};
    assign a_step_s = diff_s[NBITS+1] ? shift_s[NBITS:0] : diff_s[NBITS:0];
    assign q_step_s = {q_q[NBITS-2:0], ~diff_s[NBITS+1]};

    assign istream_rdy = reset && (state_q == IDLE);
    assign ostream_val = reset && (state_q == DONE);
    assign ostream_msg = reset ? res_q : {(2*NBITS){1'b0}};

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
`ifdef IDIV_SIGNED_EN
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
`endif
        case (state_q)
            IDLE: begin
                if (istream_val) begin
                    state_d = CALC;
                    a_d     = {(NBITS+1){1'b0}};
                    q_d     = dvd_mag_s;
                    dvs_d   = dvs_mag_s;
                    cnt_d   = CNT_LAST;
`ifdef IDIV_SIGNED_EN
                    neg_quo_d = (dvd_in_s[NBITS-1] ^ dvs_in_s[NBITS-1]) &&
                                (dvs_in_s != {NBITS{1'b0}});
                    neg_rem_d = dvd_in_s[NBITS-1];
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                a_d = a_step_s;
                q_d = q_step_s;
                if (cnt_q == CNT_ZERO) begin
                    state_d = DONE;
                    res_d   = {rem_fix_s, quo_fix_s};
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            DONE: begin
                if (ostream_rdy) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            a_q     <= {(NBITS+1){1'b0}};
            q_q     <= {NBITS{1'b0}};
            dvs_q   <= {NBITS{1'b0}};
            cnt_q   <= CNT_ZERO;
            res_q   <= {(2*NBITS){1'b0}};
`ifdef IDIV_SIGNED_EN
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
`ifdef IDIV_SIGNED_EN
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
`endif
        end
    end

endmodule

// File: tb/tb_idiv_int_div_iterative.sv
// Directed self-checking bench for idiv_int_div_iterative (unsigned or IDIV_SIGNED_EN builds).
module tb_idiv_int_div_iterative;

    localparam int NBITS = 32;

    logic               clk = 1'b0;
    logic               reset;
    logic               istream_val;
    logic               istream_rdy;
    logic [2*NBITS-1:0] istream_msg;
    logic               ostream_val;
    logic               ostream_rdy;
    logic [2*NBITS-1:0] ostream_msg;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    idiv_int_div_iterative #(.NBITS(NBITS)) dut (
        .clk         (clk),
        .reset       (reset),
        .istream_val (istream_val),
        .istream_rdy (istream_rdy),
        .istream_msg (istream_msg),
        .ostream_val (ostream_val),
        .ostream_rdy (ostream_rdy),
        .ostream_msg (ostream_msg)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one request, check latency and result; optionally stall the consumer for 'hold' cycles.
    task automatic do_div(input string tag, input logic [31:0] dvd, input logic [31:0] dvs,
                          input logic [31:0] exp_r, input logic [31:0] exp_q, input int hold);
        int cyc;
        logic [63:0] held;
        @(negedge clk);
        istream_val = 1'b1;
        istream_msg = {dvd, dvs};
        cyc = 0;
        while (!istream_rdy && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check_val({tag, "_in_rdy"}, {63'd0, istream_rdy}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        istream_val = 1'b0;
        cyc = 1;
        while (!ostream_val && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check_val({tag, "_latency"}, 64'(cyc), 64'(NBITS + 1));
        check_val({tag, "_msg"}, ostream_msg, {exp_r, exp_q});
        held = ostream_msg;
        for (int i = 0; i < hold; i++) begin
            istream_val = 1'b1;
            istream_msg = {32'd9, 32'd3};
            @(negedge clk);
            check_val({tag, "_hold_msg"}, ostream_msg, held);
            check_val({tag, "_hold_val"}, {63'd0, ostream_val}, 64'd1);
            check_val({tag, "_hold_in_rdy"}, {63'd0, istream_rdy}, 64'd0);
        end
        ostream_rdy = 1'b1;
        @(negedge clk);
        ostream_rdy = 1'b0;
        istream_val = 1'b0;
        check_val({tag, "_val_drop"}, {63'd0, ostream_val}, 64'd0);
    endtask

    initial begin
        int cyc;
        int seen;
        reset       = 1'b0;
        istream_val = 1'b0;
        istream_msg = 64'd0;
        ostream_rdy = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_in_rdy", {63'd0, istream_rdy}, 64'd0);
        check_val("rst_out_val", {63'd0, ostream_val}, 64'd0);
        check_val("rst_msg", ostream_msg, 64'd0);
        reset = 1'b1;
        @(negedge clk);
        check_val("rel_in_rdy", {63'd0, istream_rdy}, 64'd1);

        do_div("basic", 32'd100, 32'd7, 32'd2, 32'd14, 0);
        do_div("div0", 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 0);
        do_div("bp", 32'd20, 32'd6, 32'd2, 32'd3, 10);
        do_div("after_bp", 32'd9, 32'd3, 32'd0, 32'd3, 0);
        do_div("max_by1", 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 0);
        do_div("small", 32'd5, 32'd9, 32'd5, 32'd0, 0);
`ifdef IDIV_SIGNED_EN
        do_div("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 0);
        do_div("neg7_2", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        do_div("7_neg2", 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 0);
`else
        do_div("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 0);
        do_div("neg7_2", 32'hFFFF_FFF9, 32'd2, 32'd1, 32'h7FFF_FFFC, 0);
        do_div("7_neg2", 32'd7, 32'hFFFF_FFFE, 32'd7, 32'd0, 0);
`endif
        do_div("neg_div0", 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 0);

        // Abort a request mid-iteration with reset.
        @(negedge clk);
        istream_val = 1'b1;
        istream_msg = {32'd50, 32'd5};
        @(posedge clk);
        @(negedge clk);
        istream_val = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_val("mid_rst_in_rdy", {63'd0, istream_rdy}, 64'd0);
        check_val("mid_rst_msg", ostream_msg, 64'd0);
        reset = 1'b1;
        @(negedge clk);
        check_val("mid_rel_in_rdy", {63'd0, istream_rdy}, 64'd1);
        seen = 0;
        for (cyc = 0; cyc < 40; cyc++) begin
            if (ostream_val) seen++;
            @(negedge clk);
        end
        check_val("mid_rst_no_result", 64'(seen), 64'd0);

        do_div("recover", 32'd1000, 32'd10, 32'd0, 32'd100, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
